dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 24-bit data RAM between the ASIP memory stage (CPU port) and an external host/loader port (image preload, result dump).
- Sits between the processor core and the RAM instance.
- Drives the RAM address, write data and write enable.
- Asserts a stall toward the core when the host owns the RAM.
- RAM is written and read on the falling clock edge, so read data is valid in the same cycle as the address.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 24, RAM word width.
- MAX_WAIT, 4, maximum cycles a pending host request may be denied before forced grant (range 1..15).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  core memory access this cycle.
- cpu_we  in  1  core write enable.
- cpu_addr  in  ADDR_W  core address.
- cpu_wdata  in  DATA_W  core write data.
- cpu_rdata  out  DATA_W  read data to core, same cycle as a granted access.
- cpu_stall  out  1  core must hold its memory-stage instruction.
- host_req  in  1  host access request, held until host_gnt.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rvalid  out  1  host read data valid, one cycle after a read grant.
- host_rdata  out  DATA_W  registered host read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data.
- wait_cnt  out  4  current host starvation count (debug).

Behaviour:
- States: S_CPU (default owner), S_HOST (host access cycle). Reset forces S_CPU.
- Reset values: host_gnt=0, host_rvalid=0, host_rdata=0, wait_cnt=0, cpu_stall=0.
- S_CPU:
  - ram_* muxed from the cpu_* signals.
  - ram_we = cpu_req & cpu_we.
  - cpu_rdata = ram_rdata.
  - When only the host requests: next state S_HOST.
  - When both request: the CPU is served and wait_cnt increments. When wait_cnt reaches MAX_WAIT-1 on a contested cycle, next state is S_HOST (forced).
  - When host_req is low, wait_cnt clears to 0.
- S_HOST, exactly one cycle:
  - ram_* muxed from the host_* signals; ram_we = host_we.
  - host_gnt=1 (combinational).
  - cpu_stall = cpu_req.
  - host_rdata <= ram_rdata and host_rvalid <= ~host_we at the clock edge.
  - wait_cnt clears.
  - Next state: S_CPU.
- Back-to-back host requests: after each S_HOST at least one S_CPU cycle follows. Host throughput is at most 1 access per 2 cycles when the CPU is idle.
- host_rvalid is a single-cycle pulse; host_rdata holds its value until the next host read.
- cpu_stall is never asserted in S_CPU. The CPU is stalled for at most 1 cycle per MAX_WAIT contested cycles.
- When cpu_req=0 in S_CPU, ram_we=0 and ram_addr=cpu_addr; no write can occur.
- Reset asserted mid-S_HOST:
  - Immediate return to S_CPU; host_gnt drops.
  - Any pending host_rvalid is cancelled.
  - The host must reissue its request.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: a last-owner flag (reset 0 = CPU) replaces the starvation counter for contested cycles. When both request and the last owner was the CPU, the host is granted (S_HOST); otherwise the CPU is granted. wait_cnt is tied to 0.
- Undefined: CPU-priority with MAX_WAIT forced grant, as described in Behaviour.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr 0x0010, data 0xABCDEF, then a read of 0x0010 -> cpu_rdata=0xABCDEF same cycle; cpu_stall stays 0.
- Host only: host_req write 0x0100=0x123456, then host read 0x0100 -> host_gnt one cycle each, with at least 1 idle cycle between; host_rvalid pulses the cycle after the read grant with host_rdata=0x123456.
- Contention, MAX_WAIT=4: cpu_req and host_req held high continuously -> host_gnt on the 5th cycle; cpu_stall=1 that cycle only; pattern repeats every 5 cycles; wait_cnt counts 0,1,2,3.
- Host write collides with CPU read of the same address 0x0200 -> CPU read after the host grant returns the host data, 0x00F00D.
- reset driven low while in S_HOST with a read pending -> host_gnt, host_rvalid, wait_cnt and cpu_stall become 0 asynchronously; no host_rvalid after release.
- With DMEM_ARB_ROUND_ROBIN_EN, both requesting continuously -> grants alternate CPU, host, CPU, host; cpu_stall high every other cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data RAM between the ASIP memory stage (CPU port)
// and an external host/loader port (image preload, result dump).
//
// The CPU owns the RAM by default (S_CPU). A host access takes exactly one
// S_HOST cycle, during which the core is stalled if it also wants the RAM.
// An S_CPU cycle always follows an S_HOST cycle. The RAM reads and writes on
// the falling clock edge, so read data is valid in the same cycle as the
// address it belongs to.
//
// Arbitration of contested cycles (both sides requesting):
//   default build                   : CPU priority. The host is granted after
//                                     MAX_WAIT contested cycles at most.
//   `define DMEM_ARB_ROUND_ROBIN_EN : last-owner round robin. wait_cnt is
//                                     tied to zero.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata core memory-stage access
//   cpu_rdata, cpu_stall  read data to the core, hold request to the core
//   host_req/we/addr/wdata host access, held until host_gnt
//   host_gnt              host access performed this cycle
//   host_rvalid/rdata     registered host read data, one cycle after grant
//   ram_addr/wdata/we     RAM control
//   ram_rdata             RAM read data
//   wait_cnt              host starvation count (debug)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 24,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [3:0]        wait_cnt
);

    typedef enum logic {
        S_CPU  = 1'b0,
        S_HOST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Owner encoding of the last-owner flag: 0 = CPU, 1 = host.
    logic last_owner_q, last_owner_d;
    logic last_owner_s;
`else
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT - 1);
`endif

    // Next-state, RAM mux and handshake outputs.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_req & cpu_we;
        host_gnt  = 1'b0;
        cpu_stall = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        // An S_CPU cycle with a CPU access is itself a CPU turn, so it is
        // the owner that the contest decision looks back on.
        last_owner_s = last_owner_q;
        if ((state_q == S_CPU) && cpu_req) begin
            last_owner_s = 1'b0;
        end else begin
            last_owner_s = last_owner_q;
        end
        last_owner_d = last_owner_s;
`endif

        case (state_q)
            S_CPU: begin
                if (!host_req) begin
                    wait_d  = 4'd0;
                    state_d = S_CPU;
                end else if (!cpu_req) begin
                    state_d = S_HOST;
                end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    wait_d = 4'd0;
                    if (last_owner_s == 1'b0) begin
                        state_d = S_HOST;
                    end else begin
                        state_d = S_CPU;
                    end
`else
                    // Contested: CPU is served now; the host is forced in
                    // once it has been denied MAX_WAIT times.
                    wait_d = wait_q + 4'd1;
                    if (wait_q >= WAIT_LIMIT) begin
                        state_d = S_HOST;
                    end else begin
                        state_d = S_CPU;
                    end
`endif
                end
            end

            S_HOST: begin
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
                ram_we    = host_we;
                host_gnt  = 1'b1;
                cpu_stall = cpu_req;
                rvalid_d  = ~host_we;
                if (!host_we) begin
                    rdata_d = ram_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
                wait_d  = 4'd0;
                state_d = S_CPU;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                last_owner_d = 1'b1;
`endif
            end

            default: begin
                wait_d  = 4'd0;
                state_d = S_CPU;
            end
        endcase
    end

    // State, starvation counter and host read-data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CPU;
            wait_q   <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Last-owner flag for round-robin contest resolution.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    assign cpu_rdata   = ram_rdata;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign wait_cnt    = wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the sharing
// rules and a shadow copy of the RAM contents.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 24;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic [DW-1:0] cpu_rdata, host_rdata, ram_wdata, ram_rdata;
    logic          cpu_stall, host_gnt, host_rvalid, ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    wait_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .wait_cnt(wait_cnt)
    );

    // Falling-edge RAM: write then read the addressed word.
    logic [DW-1:0] ram_mem [0:65535];
    always @(negedge clk) begin
        if (ram_we === 1'b1) ram_mem[ram_addr] = ram_wdata;
        ram_rdata = ram_mem[ram_addr];
    end

    // Behavioural model: who owns the next cycle, starvation count,
    // registered host read results, expected memory contents.
    logic [DW-1:0] shadow [0:65535];
    bit            m_host;
    int            m_wait;
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;

    bit            e_gnt, e_stall, e_we, e_rvalid, e_cpu_rd;
    logic [3:0]    e_wait;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata, e_cpu_rdata;

    task automatic model_reset();
        m_host   = 1'b0;
        m_wait   = 0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // Drive one cycle of stimulus, derive expectations, advance the model,
    // and return just after the falling edge (outputs settled).
    task automatic apply(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                         input logic [DW-1:0] cwd, input bit hreq, input bit hwe,
                         input logic [AW-1:0] haddr, input logic [DW-1:0] hwd);
        @(posedge clk); #1;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
        e_gnt       = m_host;
        e_stall     = m_host && creq;
        e_wait      = 4'(m_wait);
        e_rvalid    = m_rvalid;
        e_rdata     = m_rdata;
        e_we        = m_host ? hwe : (creq && cwe);
        e_addr      = m_host ? haddr : caddr;
        e_wdata     = m_host ? hwd : cwd;
        e_cpu_rd    = !m_host && creq && !cwe;
        e_cpu_rdata = shadow[caddr];
        if (m_host) begin
            if (hwe) shadow[haddr] = hwd;
            else     m_rdata = shadow[haddr];
            m_rvalid = !hwe;
            m_host   = 1'b0;
            m_wait   = 0;
        end else begin
            m_rvalid = 1'b0;
            if (creq && cwe) shadow[caddr] = cwd;
            if (!hreq) m_wait = 0;
            else if (!creq) m_host = 1'b1;
            else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                m_host = 1'b1;
`else
                if (m_wait >= MW - 1) m_host = 1'b1;
                m_wait = m_wait + 1;
`endif
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({host_gnt, host_rvalid, cpu_stall} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {host_gnt, host_rvalid, cpu_stall});
        end
        checks++;
        if (wait_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_wait: got %0d expected 0", wait_cnt);
        end
        checks++;
        if (host_rdata !== 24'h000000) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 000000", host_rdata);
        end
        cpu_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_cpu_only();
        apply(1, 1, 16'h0010, 24'hABCDEF, 0, 0, '0, '0);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h0010 || ram_wdata !== 24'hABCDEF) begin
            failures++;
            $display("FAIL cpu_write: got we=%b addr=%h data=%h expected 1/0010/abcdef",
                     ram_we, ram_addr, ram_wdata);
        end
        apply(1, 0, 16'h0010, 24'h000000, 0, 0, '0, '0);
        checks++;
        if (cpu_rdata !== 24'hABCDEF) begin
            failures++;
            $display("FAIL cpu_read: got %h expected abcdef", cpu_rdata);
        end
        checks++;
        if (cpu_stall !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL cpu_stall_we: got %b%b expected 00", cpu_stall, ram_we);
        end
        apply(0, 1, 16'h0010, 24'h555555, 0, 0, '0, '0);
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 16'h0010) begin
            failures++;
            $display("FAIL cpu_noreq_we: got we=%b addr=%h expected 0/0010", ram_we, ram_addr);
        end
    endtask

    task automatic test_host_only();
        bit exp_g [0:5] = '{0, 1, 0, 1, 0, 0};
        bit exp_v [0:5] = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            if (i < 2)      apply(0, 0, '0, '0, 1, 1, 16'h0100, 24'h123456);
            else if (i < 4) apply(0, 0, '0, '0, 1, 0, 16'h0100, 24'h000000);
            else            apply(0, 0, '0, '0, 0, 0, '0, '0);
            checks++;
            if (host_gnt !== exp_g[i]) begin
                failures++;
                $display("FAIL host_gnt[%0d]: got %b expected %b", i, host_gnt, exp_g[i]);
            end
            checks++;
            if (host_rvalid !== exp_v[i]) begin
                failures++;
                $display("FAIL host_rvalid[%0d]: got %b expected %b", i, host_rvalid, exp_v[i]);
            end
        end
        checks++;
        if (host_rdata !== 24'h123456) begin
            failures++;
            $display("FAIL host_rdata_hold: got %h expected 123456", host_rdata);
        end
    endtask

    task automatic test_contention();
        bit eg;
        idle(2);
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 16'(i), '0, 1, 0, 16'h0100, '0);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            eg = (i % 2) == 1;
`else
            eg = (i % 5) == 4;
`endif
            checks++;
            if (host_gnt !== eg || cpu_stall !== eg) begin
                failures++;
                $display("FAIL contention_gnt[%0d]: got gnt=%b stall=%b expected %b",
                         i, host_gnt, cpu_stall, eg);
            end
            if (!eg) begin
                checks++;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (wait_cnt !== 4'd0) begin
                    failures++;
                    $display("FAIL contention_wait[%0d]: got %0d expected 0", i, wait_cnt);
                end
`else
                if (wait_cnt !== 4'(i % 5)) begin
                    failures++;
                    $display("FAIL contention_wait[%0d]: got %0d expected %0d", i, wait_cnt, i % 5);
                end
`endif
            end
        end
        idle(2);
    endtask

    task automatic test_collision();
        bit granted = 1'b0;
        apply(1, 1, 16'h0200, 24'h111111, 0, 0, '0, '0);
        for (int i = 0; i < 20 && !granted; i++) begin
            apply(1, 0, 16'h0200, '0, 1, 1, 16'h0200, 24'h00F00D);
            granted = host_gnt;
        end
        checks++;
        if (!granted) begin
            failures++;
            $display("FAIL collision_grant: got no grant expected grant within 20 cycles");
        end
        apply(1, 0, 16'h0200, '0, 0, 0, '0, '0);
        checks++;
        if (cpu_rdata !== 24'h00F00D) begin
            failures++;
            $display("FAIL collision_read: got %h expected 00f00d", cpu_rdata);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_host();
        idle(1);
        apply(0, 0, '0, '0, 1, 0, 16'h0100, '0);
        apply(1, 0, 16'h0004, '0, 1, 0, 16'h0100, '0);
        checks++;
        if (host_gnt !== 1'b1 || cpu_stall !== 1'b1) begin
            failures++;
            $display("FAIL midhost_pre: got gnt=%b stall=%b expected 11", host_gnt, cpu_stall);
        end
        reset = 1'b0;
        cpu_req = 1'b0; host_req = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({host_gnt, host_rvalid, cpu_stall} !== 3'b000 || wait_cnt !== 4'd0) begin
            failures++;
            $display("FAIL midhost_async: got gnt/rv/stall=%b wait=%0d expected 000/0",
                     {host_gnt, host_rvalid, cpu_stall}, wait_cnt);
        end
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, '0, '0, 0, 0, '0, '0);
            checks++;
            if (host_rvalid !== 1'b0 || host_gnt !== 1'b0) begin
                failures++;
                $display("FAIL midhost_after[%0d]: got rv=%b gnt=%b expected 00", i, host_rvalid, host_gnt);
            end
        end
    endtask

    task automatic test_random();
        bit            hp = 1'b0, hwe = 1'b0, cr, cw;
        logic [AW-1:0] ha = '0, ca;
        logic [DW-1:0] hd = '0, cd;
        for (int i = 0; i < 400; i++) begin
            if (!hp) begin
                hp  = ($urandom_range(0, 2) == 0);
                hwe = $urandom_range(0, 1) == 1;
                ha  = 16'($urandom_range(0, 7));
                hd  = 24'($urandom);
            end
            cr = $urandom_range(0, 3) != 0;
            cw = $urandom_range(0, 1) == 1;
            ca = 16'($urandom_range(0, 7));
            cd = 24'($urandom);
            apply(cr, cw, ca, cd, hp, hwe, ha, hd);
            if (e_gnt) hp = 1'b0;
            checks++;
            if (host_gnt !== e_gnt || cpu_stall !== e_stall || wait_cnt !== e_wait) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: got gnt=%b stall=%b wait=%0d expected %b %b %0d",
                         i, host_gnt, cpu_stall, wait_cnt, e_gnt, e_stall, e_wait);
            end
            checks++;
            if (ram_we !== e_we || ram_addr !== e_addr || (e_we && ram_wdata !== e_wdata)) begin
                failures++;
                $display("FAIL rand_ram[%0d]: got we=%b addr=%h data=%h expected %b %h %h",
                         i, ram_we, ram_addr, ram_wdata, e_we, e_addr, e_wdata);
            end
            checks++;
            if (host_rvalid !== e_rvalid || host_rdata !== e_rdata) begin
                failures++;
                $display("FAIL rand_host_rd[%0d]: got rv=%b data=%h expected %b %h",
                         i, host_rvalid, host_rdata, e_rvalid, e_rdata);
            end
            if (e_cpu_rd) begin
                checks++;
                if (cpu_rdata !== e_cpu_rdata) begin
                    failures++;
                    $display("FAIL rand_cpu_rd[%0d]: got %h expected %h", i, cpu_rdata, e_cpu_rdata);
                end
            end
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        ram_rdata = '0;
        test_reset();
        test_cpu_only();
        test_host_only();
        test_contention();
        test_collision();
        test_reset_mid_host();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
